// File: rtl/rx_word_fifo_if.sv
// rx_word_fifo_if: serial bit input, parallel word output and status signals of rx_word_fifo
interface rx_word_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     tx_data;
    logic                     tx_vld;
    logic                     rx_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_vld;
    logic                     out_rdy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     frame_done;
    modport master (
        output tx_data, tx_vld, out_rdy,
        input  rx_ready, out_data, out_vld, fifo_count, frame_done
    );
    modport slave (
        input  tx_data, tx_vld, out_rdy,
        output rx_ready, out_data, out_vld, fifo_count, frame_done
    );
endinterface

// File: rtl/rx_word_fifo.sv
// rx_word_fifo: deserializes an MSB-first bit stream into words buffered in a first-word-fall-through FIFO
module rx_word_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int FRAME_WORDS = 4
) (
    input logic           clk,
    input logic           clr,
    rx_word_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(WIDTH);
    localparam int FW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word;
    logic [BW-1:0]    bit_cnt;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [FW-1:0]    frame_cnt;
    logic             frame_done;
    logic             last_bit;
    logic             rx_ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic             frame_end;
    assign last_bit  = bit_cnt == BW'(WIDTH - 1);
    // only the final bit of a word waits for a free slot, so a word is never dropped
    assign rx_ready  = !(last_bit && count == CW'(DEPTH));
    assign accept    = bus.tx_vld && rx_ready;
    assign push      = accept && last_bit;
    assign pop       = count != '0 && bus.out_rdy;
    assign word      = {shift[WIDTH-2:0], bus.tx_data};
    assign frame_end = frame_cnt == FW'(FRAME_WORDS - 1);
    assign bus.rx_ready   = rx_ready;
    assign bus.out_vld    = count != '0;
    assign bus.out_data   = count != '0 ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;
    assign bus.frame_done = frame_done;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            shift      <= '0;
            bit_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                shift   <= word;
                bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
            frame_done <= push && frame_end;
            if (push) frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
        end
    end
endmodule

// File: tb/tb_rx_word_fifo.sv
// tb_rx_word_fifo: randomized bench comparing rx_word_fifo against a queue-based word/bit model
module tb_rx_word_fifo;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;
    rx_word_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();
    rx_word_fifo #(.WIDTH(8), .DEPTH(4), .FRAME_WORDS(4)) dut (.clk(clk), .clr(clr), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    int mbits = 0;
    logic [7:0] mword = 8'h00;
    int mframe = 0;
    logic mfd = 1'b0;
    logic acc_last = 1'b0;
    int fd_seen = 0;
    function automatic logic m_ready();
        return !(mbits == 7 && q.size() == 4);
    endfunction
    function automatic logic [7:0] m_head();
        return q.size() != 0 ? q[0] : 8'h00;
    endfunction
    // one clock: drive inputs, let the edge happen, advance the model, settle
    task automatic step(input logic d, input logic v, input logic r, input logic c);
        logic acc, pop;
        bus.tx_data = d;
        bus.tx_vld  = v;
        bus.out_rdy = r;
        clr         = c;
        acc = v && m_ready() && !c;
        pop = r && q.size() != 0 && !c;
        @(posedge clk);
        mfd = 1'b0;
        acc_last = acc;
        if (c) begin
            q.delete();
            mbits = 0;
            mword = 8'h00;
            mframe = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                mword = {mword[6:0], d};
                mbits++;
                if (mbits == 8) begin
                    q.push_back(mword);
                    mbits = 0;
                    mframe++;
                    if (mframe == 4) begin
                        mfd = 1'b1;
                        mframe = 0;
                    end
                end
            end
        end
        #1;
        if (bus.frame_done) fd_seen++;
    endtask
    task automatic send_word(input logic [7:0] w, input logic r);
        for (int i = 7; i >= 0; i--) begin
            int n;
            n = 0;
            do begin
                step(w[i], 1'b1, r, 1'b0);
                n++;
            end while (!acc_last && n < 50);
            if (!acc_last) begin
                failures++;
                $display("FAIL send_word bit accept timeout word=%h bit=%0d", w, i);
            end
        end
    endtask
    task automatic test_reset();
        for (int i = 0; i < 5; i++) step($urandom_range(0, 1), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks += 5;
        if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL reset out_vld got=%b exp=0", bus.out_vld); end
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset out_data got=%h exp=00", bus.out_data); end
        if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL reset fifo_count got=%0d exp=0", bus.fifo_count); end
        if (bus.rx_ready !== 1'b1) begin failures++; $display("FAIL reset rx_ready got=%b exp=1", bus.rx_ready); end
        if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", bus.frame_done); end
    endtask
    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hA5;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            checks++;
            if (bus.rx_ready !== 1'b1) begin failures++; $display("FAIL single rx_ready bit=%0d got=%b exp=1", i, bus.rx_ready); end
            step(w[i], 1'b1, 1'b0, 1'b0);
        end
        checks += 3;
        if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL single out_vld got=%b exp=1", bus.out_vld); end
        if (bus.out_data !== 8'hA5) begin failures++; $display("FAIL single out_data got=%h exp=a5", bus.out_data); end
        if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL single fifo_count got=%0d exp=1", bus.fifo_count); end
    endtask
    task automatic test_full_stall();
        logic [7:0] w;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        fd_seen = 0;
        for (int k = 1; k <= 4; k++) send_word(8'(k), 1'b0);
        checks += 2;
        if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL stall frame_done_on_04 got=%b exp=1", bus.frame_done); end
        if (bus.fifo_count !== 3'd4) begin failures++; $display("FAIL stall fifo_count got=%0d exp=4", bus.fifo_count); end
        w = 8'h05;
        for (int i = 7; i >= 1; i--) step(w[i], 1'b1, 1'b0, 1'b0);
        checks += 3;
        if (bus.rx_ready !== 1'b0) begin failures++; $display("FAIL stall rx_ready got=%b exp=0", bus.rx_ready); end
        if (bus.out_data !== 8'h01) begin failures++; $display("FAIL stall head got=%h exp=01", bus.out_data); end
        if (fd_seen !== 1) begin failures++; $display("FAIL stall frame_done_pulses got=%0d exp=1", fd_seen); end
        step(w[0], 1'b1, 1'b1, 1'b0);
        checks += 3;
        if (bus.fifo_count !== 3'd3) begin failures++; $display("FAIL stall pop_count got=%0d exp=3", bus.fifo_count); end
        if (bus.rx_ready !== 1'b1) begin failures++; $display("FAIL stall rx_ready_after_pop got=%b exp=1", bus.rx_ready); end
        if (bus.out_data !== 8'h02) begin failures++; $display("FAIL stall head_after_pop got=%h exp=02", bus.out_data); end
        step(w[0], 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.fifo_count !== 3'd4) begin failures++; $display("FAIL stall push_count got=%0d exp=4", bus.fifo_count); end
    endtask
    task automatic test_drain();
        for (int k = 2; k <= 5; k++) begin
            checks += 2;
            if (bus.out_vld !== 1'b1) begin failures++; $display("FAIL drain out_vld k=%0d got=%b exp=1", k, bus.out_vld); end
            if (bus.out_data !== 8'(k)) begin failures++; $display("FAIL drain out_data got=%h exp=%h", bus.out_data, 8'(k)); end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks += 2;
        if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL drain empty_vld got=%b exp=0", bus.out_vld); end
        if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL drain empty_count got=%0d exp=0", bus.fifo_count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL drain underflow_count got=%0d exp=0", bus.fifo_count); end
        end
    endtask
    task automatic test_back_to_back();
        logic [7:0] sent[$];
        logic [7:0] rcv[$];
        logic [7:0] w;
        logic r;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            w = 8'($urandom);
            sent.push_back(w);
            for (int i = 7; i >= 0; i--) begin
                r = k > 0 && i == 0;
                if (r && bus.out_vld) rcv.push_back(bus.out_data);
                step(w[i], 1'b1, r, 1'b0);
                checks++;
                if (bus.fifo_count !== 3'(q.size())) begin failures++; $display("FAIL b2b fifo_count got=%0d exp=%0d", bus.fifo_count, q.size()); end
                if (k > 0 && i == 0) begin
                    checks++;
                    if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL b2b push_pop_count got=%0d exp=1", bus.fifo_count); end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.out_vld) rcv.push_back(bus.out_data);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++;
        if (rcv.size() != 10) begin failures++; $display("FAIL b2b word_count got=%0d exp=10", rcv.size()); end
        for (int k = 0; k < 10 && k < rcv.size(); k++) begin
            checks++;
            if (rcv[k] !== sent[k]) begin failures++; $display("FAIL b2b order idx=%0d got=%h exp=%h", k, rcv[k], sent[k]); end
        end
    endtask
    task automatic test_sparse_valid();
        logic [7:0] w;
        int i, n;
        logic v;
        w = 8'h3C;
        i = 7;
        n = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        while (i >= 0 && n < 400) begin
            v = $urandom_range(0, 2) == 0;
            step(v ? w[i[2:0]] : 1'($urandom), v, 1'b0, 1'b0);
            if (acc_last) i--;
            n++;
        end
        checks += 3;
        if (i >= 0) begin failures++; $display("FAIL sparse timeout bits_left=%0d exp=0", i + 1); end
        if (bus.out_data !== 8'h3C) begin failures++; $display("FAIL sparse out_data got=%h exp=3c", bus.out_data); end
        if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL sparse fifo_count got=%0d exp=1", bus.fifo_count); end
    endtask
    task automatic test_clear_mid();
        logic [7:0] w;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) send_word(8'($urandom), 1'b0);
        w = 8'($urandom);
        for (int i = 7; i >= 4; i--) step(w[i], 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        fd_seen = 0;
        checks += 4;
        if (bus.out_vld !== 1'b0) begin failures++; $display("FAIL clrmid out_vld got=%b exp=0", bus.out_vld); end
        if (bus.fifo_count !== 3'd0) begin failures++; $display("FAIL clrmid fifo_count got=%0d exp=0", bus.fifo_count); end
        if (bus.rx_ready !== 1'b1) begin failures++; $display("FAIL clrmid rx_ready got=%b exp=1", bus.rx_ready); end
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL clrmid out_data got=%h exp=00", bus.out_data); end
        send_word(8'hFF, 1'b0);
        checks += 2;
        if (bus.out_data !== 8'hFF) begin failures++; $display("FAIL clrmid ff_data got=%h exp=ff", bus.out_data); end
        if (bus.fifo_count !== 3'd1) begin failures++; $display("FAIL clrmid ff_count got=%0d exp=1", bus.fifo_count); end
        send_word(8'($urandom), 1'b0);
        send_word(8'($urandom), 1'b0);
        checks++;
        if (fd_seen !== 0) begin failures++; $display("FAIL clrmid early_frame_done got=%0d exp=0", fd_seen); end
        send_word(8'($urandom), 1'b0);
        checks += 2;
        if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL clrmid frame_done got=%b exp=1", bus.frame_done); end
        if (fd_seen !== 1) begin failures++; $display("FAIL clrmid frame_pulses got=%0d exp=1", fd_seen); end
    endtask
    task automatic test_random_soak();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b0);
            checks += 5;
            if (bus.out_vld !== (q.size() != 0)) begin failures++; $display("FAIL soak out_vld cyc=%0d got=%b exp=%b", n, bus.out_vld, q.size() != 0); end
            if (bus.out_data !== m_head()) begin failures++; $display("FAIL soak out_data cyc=%0d got=%h exp=%h", n, bus.out_data, m_head()); end
            if (bus.fifo_count !== 3'(q.size())) begin failures++; $display("FAIL soak fifo_count cyc=%0d got=%0d exp=%0d", n, bus.fifo_count, q.size()); end
            if (bus.rx_ready !== m_ready()) begin failures++; $display("FAIL soak rx_ready cyc=%0d got=%b exp=%b", n, bus.rx_ready, m_ready()); end
            if (bus.frame_done !== mfd) begin failures++; $display("FAIL soak frame_done cyc=%0d got=%b exp=%b", n, bus.frame_done, mfd); end
        end
    endtask
    initial begin
        bus.tx_data = 1'b0;
        bus.tx_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_single_word();
        test_full_stall();
        test_drain();
        test_back_to_back();
        test_sparse_valid();
        test_clear_mid();
        test_random_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_word_fifo.md
Name: rx_word_fifo

Overview:
- Downstream consumer of the serial TX link. Accepts the 1-bit tx_data/tx_vld stream under an rx_ready handshake.
- Deserializes the bits MSB-first into WIDTH-bit words and buffers them in a DEPTH-entry FIFO.
- Presents the words on a parallel valid/ready port to the next stage.
- Pulses frame_done each time FRAME_WORDS words have been buffered.

Parameters:
WIDTH, 8, bits per assembled word
DEPTH, 4, FIFO entries; power of two, >= 2
FRAME_WORDS, 4, words per frame for frame_done; >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
clr  input  1  synchronous active-high reset
tx_data  input  1  serial data bit from TX
tx_vld  input  1  tx_data is valid this cycle
rx_ready  output  1  block can accept a bit this cycle
out_data  output  WIDTH  word at FIFO head (first-word-fall-through)
out_vld  output  1  FIFO non-empty
out_rdy  input  1  downstream accepts out_data
fifo_count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
frame_done  output  1  one-cycle pulse when a frame's last word is pushed

Behaviour:
- Reset (clr=1 at a clock edge):
  - bit_cnt=0, shift register=0, rd/wr pointers=0, fifo_count=0, frame word counter=0.
  - frame_done=0, out_vld=0, out_data=0, rx_ready=1 on the following cycle.
  - A partially assembled word and all stored words are discarded.
  - clr overrides every other event in the same cycle.
- Bit accept: occurs when tx_vld && rx_ready at the edge.
  - Shift register becomes {shift[WIDTH-2:0], tx_data}, so the first bit received is the word MSB.
  - bit_cnt increments.
  - When tx_vld=0 the block holds state; no timeout applies.
- Word push: when a bit is accepted with bit_cnt==WIDTH-1:
  - the complete word {shift[WIDTH-2:0], tx_data} is written at wr_ptr;
  - wr_ptr increments modulo DEPTH; bit_cnt returns to 0.
  - The word is visible on out_data/out_vld on the next cycle, i.e. one cycle after the last bit is accepted.
- rx_ready = !(bit_cnt==WIDTH-1 && fifo_count==DEPTH).
  - Driven from registered state only; no combinational path from out_rdy or tx_vld.
  - Bits 0..WIDTH-2 of a word are always accepted, even when the FIFO is full. Only the final bit stalls until a slot frees.
  - A word is never dropped; overflow is impossible by construction.
- Pop:
  - out_vld = (fifo_count != 0).
  - out_data = mem[rd_ptr] when out_vld=1, else 0.
  - A pop occurs on out_vld && out_rdy: rd_ptr increments modulo DEPTH.
  - out_rdy while empty has no effect (no underflow).
- fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop when full cannot occur, since push requires !full at the start of the cycle.
  - A pop while full frees a slot; the stalled last bit is accepted the next cycle.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally.
- frame_done:
  - The frame word counter increments per push.
  - On the push that makes it FRAME_WORDS, frame_done=1 for exactly one cycle (registered, same edge as the push) and the counter returns to 0.
  - Otherwise frame_done=0.
  - Pops do not affect the frame counter.

Test Plan:
1. After clr, stream bits 1,0,1,0,0,1,0,1 with tx_vld=1 and out_rdy=0 -> one cycle after the 8th bit: out_vld=1, out_data=8'hA5, fifo_count=1, rx_ready stays 1 throughout.
2. Hold out_rdy=0 and send 4 words 8'h01,8'h02,8'h03,8'h04, then the first 7 bits of 8'h05 -> fifo_count=4, frame_done pulses once on the push of 8'h04, rx_ready=0 at bit_cnt=7. Raise out_rdy for one cycle -> 8'h01 popped, the 8th bit is accepted next cycle, 8'h05 is pushed, fifo_count=4.
3. Drain the FIFO with out_rdy=1 continuously -> outputs 8'h02,8'h03,8'h04,8'h05 in order on consecutive cycles, then out_vld=0 and fifo_count=0; extra out_rdy cycles leave fifo_count=0.
4. With a steady stream and out_rdy=1, push and pop in the same cycle -> fifo_count unchanged; after 10 words the pointers have wrapped twice and all data comes out in order.
5. Toggle tx_vld randomly (1 of 3 cycles) while sending 8'h3C -> out_data=8'h3C; bits are sampled only on tx_vld && rx_ready cycles.
6. Send 3 words plus 4 bits, then assert clr for one cycle -> out_vld=0, fifo_count=0, bit_cnt=0, rx_ready=1. A subsequent full word 8'hFF appears alone, and frame_done does not pulse until 4 further words are pushed.
